// File: rtl/fwrisc_fetch.sv
// fwrisc_fetch -- instruction fetch stage of the pipelined fwrisc core.
//
// This stage owns the architectural PC. It issues word reads to the
// instruction memory and registers the returned instruction together with
// its PC. It holds that instruction for decode until decode_complete. It
// then advances the PC sequentially, or redirects it to the branch target.
//
// Optional feature macro: FWRISC_FETCH_COMPRESSED_EN
//   When this macro is defined, RV32C halfword alignment is supported. A
//   32-bit instruction that straddles a word boundary is assembled from two
//   reads, using a 16-bit hold register and the S_FETCH2 state. When the
//   macro is undefined, the PC is always word aligned and instr_c is always 0.
//
// Ports:
//   clock, reset      core clock; synchronous active-high reset
//   iaddr, ivalid     memory read request (word address), held until iready
//   iready, idata     memory accept strobe and same-cycle read data
//   fetch_valid       instr/instr_c/pc are valid for decode
//   decode_complete   decode has consumed the current instruction
//   instr, instr_c    fetched instruction; compressed-instruction flag
//   pc                address of instr
//   branch_taken      sampled with decode_complete; redirect to branch_target
//   branch_target     redirect address
module fwrisc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ivalid,
    input  logic        iready,
    input  logic [31:0] idata,
    output logic        fetch_valid,
    input  logic        decode_complete,
    output logic [31:0] instr,
    output logic        instr_c,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
);

`ifdef FWRISC_FETCH_COMPRESSED_EN
    typedef enum logic [1:0] {S_FETCH, S_FETCH2, S_VALID} state_t;
    localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFE;
`else
    typedef enum logic [1:0] {S_FETCH, S_VALID} state_t;
    localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFC;
`endif

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        instr_c_reg, instr_c_next;
    // run_reg keeps ivalid low while reset is applied, and for the edge that
    // samples it. The first request therefore appears only after reset is
    // released.
    logic        run_reg;
`ifdef FWRISC_FETCH_COMPRESSED_EN
    logic [15:0] hold_reg, hold_next;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_VECTOR;
            instr_reg   <= 32'h0;
            instr_c_reg <= 1'b0;
            run_reg     <= 1'b0;
`ifdef FWRISC_FETCH_COMPRESSED_EN
            hold_reg    <= 16'h0;
`endif
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            instr_c_reg <= instr_c_next;
            run_reg     <= 1'b1;
`ifdef FWRISC_FETCH_COMPRESSED_EN
            hold_reg    <= hold_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        instr_c_next = instr_c_reg;
`ifdef FWRISC_FETCH_COMPRESSED_EN
        hold_next    = hold_reg;
`endif
        case (state_reg)
            S_FETCH: begin
                if (run_reg && iready) begin
`ifdef FWRISC_FETCH_COMPRESSED_EN
                    if (!pc_reg[1]) begin
                        if (idata[1:0] != 2'b11) begin
                            instr_next   = {16'h0, idata[15:0]};
                            instr_c_next = 1'b1;
                        end else begin
                            instr_next   = idata;
                            instr_c_next = 1'b0;
                        end
                        state_next = S_VALID;
                    end else if (idata[17:16] != 2'b11) begin
                        instr_next   = {16'h0, idata[31:16]};
                        instr_c_next = 1'b1;
                        state_next   = S_VALID;
                    end else begin
                        // The upper half starts a 32-bit instruction. Keep it
                        // and read the next word to get the upper 16 bits.
                        hold_next  = idata[31:16];
                        state_next = S_FETCH2;
                    end
`else
                    instr_next   = idata;
                    instr_c_next = 1'b0;
                    state_next   = S_VALID;
`endif
                end
            end
`ifdef FWRISC_FETCH_COMPRESSED_EN
            S_FETCH2: begin
                if (run_reg && iready) begin
                    instr_next   = {idata[15:0], hold_reg};
                    instr_c_next = 1'b0;
                    state_next   = S_VALID;
                end
            end
`endif
            S_VALID: begin
                if (decode_complete) begin
                    if (branch_taken) begin
                        pc_next = branch_target & TARGET_MASK;
                    end else begin
                        pc_next = pc_reg + (instr_c_reg ? 32'd2 : 32'd4);
                    end
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign ivalid      = run_reg && (state_reg != S_VALID);
    assign fetch_valid = (state_reg == S_VALID);
    assign instr       = instr_reg;
    assign instr_c     = instr_c_reg;
    assign pc          = pc_reg;

`ifdef FWRISC_FETCH_COMPRESSED_EN
    assign iaddr = (state_reg == S_FETCH2) ? {pc_reg[31:2] + 30'd1, 2'b00}
                                           : {pc_reg[31:2], 2'b00};
`else
    assign iaddr = {pc_reg[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Testbench for fwrisc_fetch. The main fetch/decode handshake is driven from
// a table of transactions. Hand-written sequences cover reset abandonment,
// ignored decode_complete and, when compressed support is built in, the
// halfword-aligned fetch cases.
module tb_fwrisc_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic        fetch_valid;
    logic        decode_complete;
    logic [31:0] instr;
    logic        instr_c;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] branch_target;

    int n_pass  = 0;
    int n_total = 0;

    fwrisc_fetch #(.RESET_VECTOR(32'h8000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .iaddr           (iaddr),
        .ivalid          (ivalid),
        .iready          (iready),
        .idata           (idata),
        .fetch_valid     (fetch_valid),
        .decode_complete (decode_complete),
        .instr           (instr),
        .instr_c         (instr_c),
        .pc              (pc),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;      // word returned by memory
        int          mem_wait;  // cycles iready is held low
        int          dec_wait;  // cycles decode_complete is held low
        logic        bt;        // branch_taken with decode_complete
        logic [31:0] tgt;       // branch_target with decode_complete
        logic [31:0] exp_addr;  // expected iaddr and pc for this fetch
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ivalid();
        int cnt = 0;
        while (ivalid !== 1'b1 && cnt < 8) begin
            step();
            cnt++;
        end
        chk("ivalid_wait", {31'h0, ivalid}, 32'h1);
    endtask

    initial begin
        // The table rows run in order, and each row follows from the PC that
        // the previous row left behind.
        vecs[0] = '{32'h0000_0013, 0, 0, 1'b0, 32'h0,         32'h8000_0000};
        vecs[1] = '{32'h0010_0093, 3, 5, 1'b1, 32'h8000_0100, 32'h8000_0004};
        vecs[2] = '{32'h0020_0113, 0, 0, 1'b1, 32'hFFFF_FFFC, 32'h8000_0100};
        vecs[3] = '{32'h0030_0193, 1, 1, 1'b0, 32'h0,         32'hFFFF_FFFC};
        vecs[4] = '{32'h0040_0213, 0, 2, 1'b1, 32'h1234_5679, 32'h0000_0000};
        vecs[5] = '{32'h0050_0293, 2, 0, 1'b0, 32'h0,         32'h1234_5678};

        reset = 1'b1; iready = 1'b0; idata = 32'h0;
        decode_complete = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        step(); step();
        chk("rst_ivalid",      {31'h0, ivalid},      32'h0);
        chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_instr",       instr,                32'h0);
        chk("rst_instr_c",     {31'h0, instr_c},     32'h0);
        chk("rst_pc",          pc,                   32'h8000_0000);
        chk("rst_iaddr",       iaddr,                32'h8000_0000);

        reset = 1'b0;
        step();
        chk("first_ivalid", {31'h0, ivalid}, 32'h1);

        for (int i = 0; i < 6; i++) begin
            wait_ivalid();
            chk($sformatf("v%0d_iaddr", i), iaddr, vecs[i].exp_addr);
            for (int w = 0; w < vecs[i].mem_wait; w++) begin
                step();
                chk($sformatf("v%0d_wait_ivalid", i), {31'h0, ivalid}, 32'h1);
                chk($sformatf("v%0d_wait_iaddr", i), iaddr, vecs[i].exp_addr);
                chk($sformatf("v%0d_wait_fv", i), {31'h0, fetch_valid}, 32'h0);
            end
            iready = 1'b1; idata = vecs[i].data;
            step();
            iready = 1'b0; idata = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_fetch_valid", i), {31'h0, fetch_valid}, 32'h1);
            chk($sformatf("v%0d_ivalid_low", i), {31'h0, ivalid}, 32'h0);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_addr);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].data);
            chk($sformatf("v%0d_instr_c", i), {31'h0, instr_c}, 32'h0);
            // Stray branch_taken and iready without decode_complete are ignored.
            for (int w = 0; w < vecs[i].dec_wait; w++) begin
                branch_taken = 1'b1; branch_target = 32'h4444_0000; iready = 1'b1;
                step();
                chk($sformatf("v%0d_hold_fv", i), {31'h0, fetch_valid}, 32'h1);
                chk($sformatf("v%0d_hold_pc", i), pc, vecs[i].exp_addr);
                chk($sformatf("v%0d_hold_instr", i), instr, vecs[i].data);
                chk($sformatf("v%0d_hold_ivalid", i), {31'h0, ivalid}, 32'h0);
            end
            iready = 1'b0;
            decode_complete = 1'b1; branch_taken = vecs[i].bt; branch_target = vecs[i].tgt;
            step();
            decode_complete = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
            chk($sformatf("v%0d_done_fv", i), {31'h0, fetch_valid}, 32'h0);
            chk($sformatf("v%0d_done_ivalid", i), {31'h0, ivalid}, 32'h1);
        end
        chk("seq_iaddr_after_table", iaddr, 32'h1234_567C);

        // Reset lands in the same cycle as the memory response.
        iready = 1'b1; idata = 32'h0000_0093; reset = 1'b1;
        step();
        reset = 1'b0; iready = 1'b0;
        chk("rstreq_fv",     {31'h0, fetch_valid}, 32'h0);
        chk("rstreq_ivalid", {31'h0, ivalid},      32'h0);
        chk("rstreq_pc",     pc,                   32'h8000_0000);
        chk("rstreq_instr",  instr,                32'h0);
        step();
        chk("rstreq_ivalid_back", {31'h0, ivalid}, 32'h1);
        chk("rstreq_iaddr",       iaddr,           32'h8000_0000);

        // decode_complete while no instruction is valid changes nothing.
        decode_complete = 1'b1; branch_taken = 1'b1; branch_target = 32'h4444_0000;
        step();
        decode_complete = 1'b0; branch_taken = 1'b0;
        chk("stray_dc_iaddr",  iaddr,           32'h8000_0000);
        chk("stray_dc_ivalid", {31'h0, ivalid}, 32'h1);
        iready = 1'b1; idata = 32'h0000_0113;
        step();
        iready = 1'b0;
        chk("stray_dc_pc",    pc,    32'h8000_0000);
        chk("stray_dc_instr", instr, 32'h0000_0113);

        // Reset while an instruction is waiting for decode.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstvalid_fv",    {31'h0, fetch_valid}, 32'h0);
        chk("rstvalid_instr", instr,                32'h0);
        chk("rstvalid_pc",    pc,                   32'h8000_0000);
        step();
        chk("rstvalid_ivalid", {31'h0, ivalid}, 32'h1);

`ifdef FWRISC_FETCH_COMPRESSED_EN
        iready = 1'b1; idata = 32'h0513_4501;
        step();
        iready = 1'b0;
        chk("c_lo_instr",   instr,              32'h0000_4501);
        chk("c_lo_instr_c", {31'h0, instr_c},   32'h1);
        chk("c_lo_pc",      pc,                 32'h8000_0000);
        decode_complete = 1'b1;
        step();
        decode_complete = 1'b0;
        chk("c_next_pc",    pc,    32'h8000_0002);
        chk("c_next_iaddr", iaddr, 32'h8000_0000);
        iready = 1'b1; idata = 32'h0513_4501;
        step();
        chk("c_f2_ivalid", {31'h0, ivalid}, 32'h1);
        chk("c_f2_iaddr",  iaddr,           32'h8000_0004);
        idata = 32'h0000_0000;
        step();
        iready = 1'b0;
        chk("c_x_instr",   instr,            32'h0000_0513);
        chk("c_x_instr_c", {31'h0, instr_c}, 32'h0);
        chk("c_x_pc",      pc,               32'h8000_0002);
        decode_complete = 1'b1;
        step();
        decode_complete = 1'b0;
        chk("c_x_next_pc", pc, 32'h8000_0006);
        chk("c_x_next_iaddr", iaddr, 32'h8000_0004);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
